// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: FSM state encoding, the zero register and the
// source-match helper that is also used by the forwarding unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_STALL = 2'd1,
    WAIT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r is a live source of the ID instruction; r0 never matches
  function automatic logic src_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != REG_ZERO) &&
           ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational hazard terms from the ID, EX and MEM register fields.
// Ports: ID rs/rt/uses_rt/is_branch, EX load/write/dest, MEM load/dest in;
// lu_o (load-use), b1_o (1-cycle branch dep), b2_o (load-to-branch) out.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       idex_mem_read,
  input  logic       idex_reg_write,
  input  logic [4:0] idex_wreg,
  input  logic       exmem_mem_read,
  input  logic [4:0] exmem_wreg,
  output logic       lu_o,
  output logic       b1_o,
  output logic       b2_o
);

  logic ex_src;
  logic mem_src;

  assign ex_src  = src_match(idex_wreg, id_rs, id_rt,
                             id_uses_rt);
  assign mem_src = src_match(exmem_wreg, id_rs, id_rt,
                             id_uses_rt);

  assign lu_o = idex_mem_read & ex_src;

  // ALU result in EX, or load data arriving in MEM:
  // branch compares in ID, so one stall is enough
  assign b1_o = id_is_branch &
                ((idex_reg_write & ~idex_mem_read & ex_src) |
                 (exmem_mem_read & mem_src));

  // load still in EX feeding an ID branch: two stalls
  assign b2_o = id_is_branch & idex_mem_read & ex_src;

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end pipeline controller: PC/IF-ID enables, IF-ID flush, ID-EX bubble,
// stall-cycle counter and sticky imem timeout. Outputs are Mealy.
// Ports: clk, rst (async high), imem_ready, ID/EX/MEM hazard fields and
// id_redirect in; pc_we, ifid_we, ifid_flush, idex_bubble, imem_timeout,
// stall_count out.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_redirect,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [4:0]       idex_wreg,
  input  logic             exmem_mem_read,
  input  logic [4:0]       exmem_wreg,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             stall;
  logic             lu, b1, b2;

  hazard_detect u_detect (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_is_branch   (id_is_branch),
    .idex_mem_read  (idex_mem_read),
    .idex_reg_write (idex_reg_write),
    .idex_wreg      (idex_wreg),
    .exmem_mem_read (exmem_mem_read),
    .exmem_wreg     (exmem_wreg),
    .lu_o           (lu),
    .b1_o           (b1),
    .b2_o           (b2)
  );

  // priority ordered: imem wait beats the pending
  // second branch stall, which beats fresh hazards
  always_comb begin
    stall   = 1'b0;
    state_d = RUN;
    if (!imem_ready) begin
      stall   = 1'b1;
      state_d = WAIT;
    end else if (state_q == BR_STALL) begin
      stall   = 1'b1;
    end else if (b2) begin
      stall   = 1'b1;
      state_d = BR_STALL;
    end else if (lu | b1) begin
      stall   = 1'b1;
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    if (!rst) begin
      pc_we       = ~stall;
      ifid_we     = ~stall;
      ifid_flush  = ~stall & id_redirect;
      idex_bubble = stall;
    end
  end

  always_comb begin
    wait_d = '0;
    if (!imem_ready)
      wait_d = (wait_q == WMAX) ? wait_q
                                : wait_q + WW'(1);
    to_d  = to_q | (wait_d == WMAX);
    cnt_d = cnt_q;
    if (stall && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign imem_timeout = to_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against an owed-stall reference model.
module tb_hazard_ctrl;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 16;

  logic clk;
  logic rst;
  logic imem_ready;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic id_uses_rt;
  logic id_is_branch;
  logic id_redirect;
  logic idex_mem_read;
  logic idex_reg_write;
  logic [4:0] idex_wreg;
  logic exmem_mem_read;
  logic [4:0] exmem_wreg;
  logic pc_we;
  logic ifid_we;
  logic ifid_flush;
  logic idex_bubble;
  logic imem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [4:0] outs;

  int checks = 0;
  int passes = 0;

  int     m_owed;
  int     m_wait;
  bit     m_to;
  longint m_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_ready     (imem_ready),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_is_branch   (id_is_branch),
    .id_redirect    (id_redirect),
    .idex_mem_read  (idex_mem_read),
    .idex_reg_write (idex_reg_write),
    .idex_wreg      (idex_wreg),
    .exmem_mem_read (exmem_mem_read),
    .exmem_wreg     (exmem_wreg),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .imem_timeout   (imem_timeout),
    .stall_count    (stall_count)
  );

  assign outs = {pc_we, ifid_we, ifid_flush,
                 idex_bubble, imem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit src(logic [4:0] r);
    return r != 5'd0 &&
           (r == id_rs || (id_uses_rt && r == id_rt));
  endfunction

  function automatic int need_stalls();
    // extra cycles ID must hold for the current hazard
    if (id_is_branch && idex_mem_read && src(idex_wreg))
      return 2;
    if (idex_mem_read && src(idex_wreg)) return 1;
    if (id_is_branch && idex_reg_write && src(idex_wreg))
      return 1;
    if (id_is_branch && exmem_mem_read && src(exmem_wreg))
      return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (!imem_ready) return 1'b1;
    if (m_owed > 0) return 1'b1;
    return need_stalls() > 0;
  endfunction

  function automatic logic [4:0] m_out();
    bit s;
    if (rst) return 5'b00110;
    s = m_stall();
    return {!s, !s, !s && id_redirect, s, m_to};
  endfunction

  task automatic m_reset();
    m_owed = 0;
    m_wait = 0;
    m_to   = 1'b0;
    m_cnt  = 0;
  endtask

  // advance model using inputs as seen at the edge, then cross it
  task automatic tick();
    if (rst) begin
      m_reset();
    end else begin
      if (m_stall() && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!imem_ready) begin
        if (m_wait < WAIT_MAX) m_wait++;
        if (m_wait == WAIT_MAX) m_to = 1'b1;
        m_owed = 0;
      end else begin
        m_wait = 0;
        if (m_owed > 0) m_owed--;
        else m_owed = need_stalls() - 1;
        if (m_owed < 0) m_owed = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_ready     = 1'b1;
    id_rs          = 5'd0;
    id_rt          = 5'd0;
    id_uses_rt     = 1'b0;
    id_is_branch   = 1'b0;
    id_redirect    = 1'b0;
    idex_mem_read  = 1'b0;
    idex_reg_write = 1'b0;
    idex_wreg      = 5'd0;
    exmem_mem_read = 1'b0;
    exmem_wreg     = 5'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 5'b00110)
        $display("FAIL reset_outs cyc%0d got=%b exp=00110",
                 i, outs);
      else passes++;
      checks++;
      if (stall_count !== '0)
        $display("FAIL reset_cnt got=%0d exp=0",
                 stall_count);
      else passes++;
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000)
      $display("FAIL reset_release got=%b exp=11000", outs);
    else passes++;
    tick();
  endtask

  task automatic test_load_use();
    idle();
    idex_mem_read = 1'b1;
    idex_wreg     = 5'd5;
    id_rs         = 5'd5;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00010)
      $display("FAIL lu_stall got=%b exp=00010", outs);
    else passes++;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000)
      $display("FAIL lu_go got=%b exp=11000", outs);
    else passes++;
    checks++;
    if (stall_count !== 1)
      $display("FAIL lu_cnt got=%0d exp=1", stall_count);
    else passes++;
    tick();
    idex_mem_read = 1'b1;
    idex_wreg     = 5'd0;
    id_rs         = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000)
      $display("FAIL lu_r0 got=%b exp=11000", outs);
    else passes++;
    tick();
    idle();
  endtask

  task automatic test_load_branch();
    idle();
    id_is_branch  = 1'b1;
    id_uses_rt    = 1'b1;
    id_rt         = 5'd7;
    idex_mem_read = 1'b1;
    idex_wreg     = 5'd7;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00010)
      $display("FAIL lb_stall1 got=%b exp=00010", outs);
    else passes++;
    tick();
    idex_mem_read = 1'b0;
    idex_wreg     = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00010)
      $display("FAIL lb_stall2 got=%b exp=00010", outs);
    else passes++;
    tick();
    exmem_wreg = 5'd7;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000)
      $display("FAIL lb_go got=%b exp=11000", outs);
    else passes++;
    tick();
    idle();
  endtask

  task automatic test_redirect();
    idle();
    id_redirect = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11100)
      $display("FAIL redir_flush got=%b exp=11100", outs);
    else passes++;
    tick();
    idex_mem_read = 1'b1;
    idex_wreg     = 5'd3;
    id_rs         = 5'd3;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00010)
      $display("FAIL redir_lu got=%b exp=00010", outs);
    else passes++;
    tick();
    idex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11100)
      $display("FAIL redir_after got=%b exp=11100", outs);
    else passes++;
    tick();
    idle();
  endtask

  task automatic test_imem_wait();
    logic [4:0] exp;
    idle();
    imem_ready  = 1'b0;
    id_redirect = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp = {4'b0001, 1'(i >= WAIT_MAX)};
      @(negedge clk);
      checks++;
      if (outs !== exp)
        $display("FAIL wait cyc%0d got=%b exp=%b",
                 i, outs, exp);
      else passes++;
      tick();
    end
    imem_ready  = 1'b1;
    id_redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11001)
      $display("FAIL wait_done got=%b exp=11001", outs);
    else passes++;
    checks++;
    if (stall_count !== m_cnt[CNT_W-1:0])
      $display("FAIL wait_cnt got=%0d exp=%0d",
               stall_count, m_cnt);
    else passes++;
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    id_is_branch  = 1'b1;
    id_rs         = 5'd9;
    idex_mem_read = 1'b1;
    idex_wreg     = 5'd9;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00011)
      $display("FAIL ar_stall got=%b exp=00011", outs);
    else passes++;
    tick();
    idle();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00110)
      $display("FAIL ar_outs got=%b exp=00110", outs);
    else passes++;
    checks++;
    if (stall_count !== '0)
      $display("FAIL ar_cnt got=%0d exp=0", stall_count);
    else passes++;
    m_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000)
      $display("FAIL ar_run got=%b exp=11000", outs);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] exp;
    for (int i = 0; i < 500; i++) begin
      imem_ready     = $urandom_range(0, 7) != 0;
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      id_uses_rt     = 1'($urandom_range(0, 1));
      id_is_branch   = 1'($urandom_range(0, 1));
      id_redirect    = 1'($urandom_range(0, 1));
      idex_mem_read  = 1'($urandom_range(0, 1));
      idex_reg_write = 1'($urandom_range(0, 1));
      idex_wreg      = 5'($urandom_range(0, 3));
      exmem_mem_read = 1'($urandom_range(0, 1));
      exmem_wreg     = 5'($urandom_range(0, 3));
      exp = m_out();
      @(negedge clk);
      checks++;
      if (outs !== exp)
        $display("FAIL rand_outs cyc%0d got=%b exp=%b",
                 i, outs, exp);
      else passes++;
      checks++;
      if (stall_count !== m_cnt[CNT_W-1:0])
        $display("FAIL rand_cnt cyc%0d got=%0d exp=%0d",
                 i, stall_count, m_cnt);
      else passes++;
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_reset();
    test_reset();
    test_load_use();
    test_load_branch();
    test_redirect();
    test_imem_wait();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
